// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the write port of an 8-deep fifo between two
// valid/ready producers. The default build is round-robin with bounded bursts.
// Defining FIFO_WR_ARB_STRICT_PRIO_EN gives requester 0 fixed priority, and
// requester 1 gets one transfer each time requester 0 completes BURST_MAX.
// F_DIN/F_WR are registered. Writes are throttled from FULL/almostFULL so the
// fifo is never overrun.
module fifo_wr_arbiter #(
  parameter int unsigned DW        = 16,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ0,
  input  logic [DW-1:0] DIN0,
  output logic          ACK0,
  input  logic          REQ1,
  input  logic [DW-1:0] DIN1,
  output logic          ACK1,
  output logic [DW-1:0] F_DIN,
  output logic          F_WR,
  input  logic          F_FULL,
  input  logic          F_AFULL,
  input  logic          F_OVER,
  output logic          OWNER,
  output logic          BUSY,
  output logic [15:0]   STALL_CNT,
  output logic          ERR
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } state_e;

  localparam logic [3:0] BurstMax = 4'(BURST_MAX);

  state_e        state_q, state_d;
  logic [3:0]    burst_q, burst_d, burst_inc;
  logic          last_q, last_d;
  logic          f_wr_q;
  logic [DW-1:0] f_din_q;
  logic          owner_q, busy_q, err_q;
  logic [15:0]   stall_q;
  logic          allow, ack0, ack1, xfer, stall;
  logic [DW-1:0] xfer_data;

  // Flow control and handshakes. A write in flight is not yet visible in the
  // flags, so almostFULL together with F_WR already means full.
  always_comb begin
    allow     = !F_FULL && !(f_wr_q && F_AFULL);
    ack0      = RST && (state_q == StOwn0) && REQ0 && allow;
    ack1      = RST && (state_q == StOwn1) && REQ1 && allow;
    xfer      = ack0 || ack1;
    xfer_data = ack1 ? DIN1 : DIN0;
    stall     = RST && !allow &&
                (((state_q == StOwn0) && REQ0) || ((state_q == StOwn1) && REQ1));
    // The burst count saturates so that a lone owner keeps the grant.
    burst_inc = (burst_q >= BurstMax) ? BurstMax : burst_q + 4'd1;
  end

  // Next-state logic for grant ownership, the burst count and last-served.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        burst_d = '0;
        if (REQ0 && REQ1) begin
`ifdef FIFO_WR_ARB_STRICT_PRIO_EN
          state_d = StOwn0;
`else
          state_d = last_q ? StOwn0 : StOwn1;
`endif
        end else if (REQ0) begin
          state_d = StOwn0;
        end else if (REQ1) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (ack0) begin
          last_d  = 1'b0;
          burst_d = burst_inc;
        end
        if (!REQ0) begin
          state_d = REQ1 ? StOwn1 : StIdle;
          burst_d = '0;
        end else if (ack0 && (burst_inc == BurstMax) && REQ1) begin
          state_d = StOwn1;
          burst_d = '0;
        end
      end
      StOwn1: begin
        if (ack1) begin
          last_d  = 1'b1;
          burst_d = burst_inc;
        end
        if (!REQ1) begin
          state_d = REQ0 ? StOwn0 : StIdle;
          burst_d = '0;
`ifdef FIFO_WR_ARB_STRICT_PRIO_EN
        // Hand back to 0 once 1 has made its transfer, regardless of burst.
        end else if (REQ0 && ack1) begin
`else
        end else if (ack1 && (burst_inc == BurstMax) && REQ0) begin
`endif
          state_d = StOwn0;
          burst_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        burst_d = '0;
      end
    endcase
  end

  // State and registered outputs. Reset drops any in-flight write.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StIdle;
      burst_q <= '0;
      last_q  <= 1'b1;
      f_wr_q  <= 1'b0;
      f_din_q <= '0;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
      f_wr_q  <= xfer;
      if (xfer) begin
        f_din_q <= xfer_data;
      end
      busy_q <= (state_d != StIdle);
      if (state_d != StIdle) begin
        owner_q <= (state_d == StOwn1);
      end
      if (stall && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (F_OVER) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ACK0      = ack0;
  assign ACK1      = ack1;
  assign F_WR      = f_wr_q;
  assign F_DIN     = f_din_q;
  assign OWNER     = owner_q;
  assign BUSY      = busy_q;
  assign STALL_CNT = stall_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a small behavioural 8-deep fifo model.
module tb_fifo_wr_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ0, REQ1, ACK0, ACK1;
  logic [15:0] DIN0, DIN1, F_DIN;
  logic        F_WR, F_FULL, F_AFULL, F_OVER;
  logic        OWNER, BUSY, ERR;
  logic [15:0] STALL_CNT;

  int checks = 0;
  int errors = 0;

  // Fifo model state and bench controls.
  int          cnt;
  int          fload;
  int          cyc = 0;
  logic        fclr, wclr, rd_en, ovr_force;
  logic        model_over;
  bit          over_seen;
  logic [15:0] wq[$];
  int          wcyc[$];
  int          n0, n1, lim0;
  logic [15:0] base0, base1;

  fifo_wr_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ0      (REQ0),
    .DIN0      (DIN0),
    .ACK0      (ACK0),
    .REQ1      (REQ1),
    .DIN1      (DIN1),
    .ACK1      (ACK1),
    .F_DIN     (F_DIN),
    .F_WR      (F_WR),
    .F_FULL    (F_FULL),
    .F_AFULL   (F_AFULL),
    .F_OVER    (F_OVER),
    .OWNER     (OWNER),
    .BUSY      (BUSY),
    .STALL_CNT (STALL_CNT),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  assign F_FULL     = (cnt == 8);
  assign F_AFULL    = (cnt == 7);
  assign model_over = F_WR && (cnt == 8);
  assign F_OVER     = ovr_force || model_over;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (model_over) over_seen <= 1'b1;
    if (fclr) cnt <= fload;
    else cnt <= cnt + ((F_WR && cnt < 8) ? 1 : 0) - ((rd_en && cnt > 0) ? 1 : 0);
  end

  // Records every word presented to the fifo.
  always @(negedge CLK) begin
    if (wclr) begin
      wq.delete();
      wcyc.delete();
    end else if (F_WR === 1'b1) begin
      wq.push_back(F_DIN);
      wcyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] wq_at(input int i);
    if (i < wq.size()) return wq[i];
    return 16'hxxxx;
  endfunction

  task automatic drive();
    DIN0 = base0 + 16'(n0);
    DIN1 = base1 + 16'(n1);
  endtask

  task automatic do_reset(input int pre);
    RST = 1'b0; fclr = 1'b1; wclr = 1'b1; fload = pre;
    REQ0 = 1'b0; REQ1 = 1'b0; rd_en = 1'b0; ovr_force = 1'b0;
    n0 = 0; n1 = 0;
    drive();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1; fclr = 1'b0; wclr = 1'b0;
  endtask

  // One clock: ACKs sampled mid-cycle decide which handshakes land on the edge.
  task automatic cycle();
    logic a0, a1;
    @(negedge CLK);
    a0 = ACK0;
    a1 = ACK1;
    @(posedge CLK);
    #1;
    if (a0) n0++;
    if (a1) n1++;
    drive();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    base0 = 16'h0000; base1 = 16'h0000;

    // Reset state.
    do_reset(0);
    chk("rst_fwr", F_WR, 0);
    chk("rst_fdin", F_DIN, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_owner", OWNER, 0);
    chk("rst_stall", STALL_CNT, 0);
    chk("rst_err", ERR, 0);

    // T1: reset in the middle of a burst from requester 0.
    do_reset(0);
    rd_en = 1'b1; REQ0 = 1'b1;
    for (int i = 0; i < 20 && n0 < 3; i++) cycle();
    chk("t1_words", n0, 3);
    chk("t1_inflight", F_WR, 1);
    RST = 1'b0;
    #1;
    chk("t1_ack0_in_rst", ACK0, 0);
    @(posedge CLK);
    #1;
    chk("t1_fwr_dropped", F_WR, 0);
    chk("t1_busy", BUSY, 0);
    RST = 1'b1; REQ1 = 1'b1;
    @(posedge CLK);
    #1;
    chk("t1_first_busy", BUSY, 1);
    chk("t1_first_owner", OWNER, 0);
    chk("t1_first_ack0", ACK0, 1);
    chk("t1_first_ack1", ACK1, 0);

    // T2: single requester fills the fifo, nothing reads.
    do_reset(0);
    base0 = 16'h0000; drive();
    REQ0 = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    chk("t2_stall_a", STALL_CNT, 11);
    chk("t2_ack0_low", ACK0, 0);
    cycle();
    chk("t2_stall_b", STALL_CNT, 12);
    chk("t2_accepted", n0, 8);
    chk("t2_nwrites", wq.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t2_word%0d", i), wq_at(i), i);
    chk("t2_err", ERR, 0);
    chk("t2_over", over_seen, 0);

    // ERR is sticky on F_OVER and cleared only by reset.
    ovr_force = 1'b1;
    @(posedge CLK);
    #1;
    ovr_force = 1'b0;
    chk("err_set", ERR, 1);
    @(posedge CLK);
    #1;
    chk("err_sticky", ERR, 1);
    do_reset(0);
    chk("err_clr", ERR, 0);
    chk("stall_clr", STALL_CNT, 0);

`ifndef FIFO_WR_ARB_STRICT_PRIO_EN
    // T3: both requesting continuously, fifo drained every cycle.
    do_reset(0);
    base0 = 16'hA000; base1 = 16'hB000; drive();
    rd_en = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1;
    for (int i = 0; i < 40 && wq.size() < 12; i++) cycle();
    chk("t3_nwrites", wq.size(), 12);
    for (int i = 0; i < 12; i++) begin
      logic [15:0] e;
      e = (i < 4) ? 16'hA000 + 16'(i) :
          (i < 8) ? 16'hB000 + 16'(i - 4) : 16'hA000 + 16'(i - 4);
      chk($sformatf("t3_word%0d", i), wq_at(i), e);
    end
    chk("t3_nogap", (wcyc.size() >= 12) ? wcyc[11] - wcyc[0] : -1, 11);
`endif

    // T4: six words preloaded; D and E fit, F waits for a read.
    do_reset(6);
    base1 = 16'h000D; drive();
    REQ1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      REQ1 = (n1 < 3);
    end
    chk("t4_accepted", n1, 2);
    chk("t4_ack1_held", ACK1, 0);
    chk("t4_nwrites", wq.size(), 2);
    chk("t4_word_d", wq_at(0), 16'h000D);
    chk("t4_word_e", wq_at(1), 16'h000E);
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      REQ1 = (n1 < 3);
    end
    chk("t4_nwrites_after", wq.size(), 3);
    chk("t4_word_f", wq_at(2), 16'h000F);
    chk("t4_over", over_seen, 0);
    chk("t4_err", ERR, 0);

    // T5: requester 0 drops after two words while requester 1 waits.
    do_reset(0);
    base0 = 16'hA000; base1 = 16'hB000; drive();
    rd_en = 1'b1; lim0 = 2; REQ0 = 1'b1; REQ1 = 1'b1;
    for (int i = 0; i < 20 && n0 < 2; i++) begin
      cycle();
      REQ0 = (n0 < lim0);
    end
    chk("t5_req0_words", n0, 2);
    cycle();
    chk("t5_owner", OWNER, 1);
    chk("t5_busy", BUSY, 1);
    lim0 = 10; REQ0 = 1'b1;
`ifndef FIFO_WR_ARB_STRICT_PRIO_EN
    for (int i = 0; i < 40 && wq.size() < 8; i++) begin
      cycle();
      REQ0 = (n0 < lim0);
    end
    chk("t5_nwrites", wq.size(), 8);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = (i < 2) ? 16'hA000 + 16'(i) :
          (i < 6) ? 16'hB000 + 16'(i - 2) : 16'hA000 + 16'(i - 4);
      chk($sformatf("t5_word%0d", i), wq_at(i), e);
    end
`endif

`ifdef FIFO_WR_ARB_STRICT_PRIO_EN
    // T6: requester 0 raised while requester 1 streams.
    do_reset(0);
    base0 = 16'hA000; base1 = 16'hB000; drive();
    rd_en = 1'b1; REQ1 = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    REQ0 = 1'b1;
    cycle();
    chk("t6_owner0", OWNER, 0);
    for (int i = 0; i < 40 && wq.size() < 11; i++) cycle();
    chk("t6_nwrites", wq.size(), 11);
    for (int i = 0; i < 11; i++) begin
      logic [15:0] e;
      e = (i < 5) ? 16'hB000 + 16'(i) :
          (i < 9) ? 16'hA000 + 16'(i - 5) :
          (i == 9) ? 16'hB005 : 16'hA004;
      chk($sformatf("t6_word%0d", i), wq_at(i), e);
    end
`endif

    REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the write port of the team's 8-deep, 16-bit `fifo` block between two producers. Arbitration is round-robin with a bounded burst length. Each producer uses a valid/ready handshake (REQx/ACKx). The block drives the FIFO's DIN/WR through registered outputs and throttles itself from the FIFO's FULL/almostFULL flags, so the FIFO is never overrun. It sits directly in front of `fifo`, with F_* ports wired to the FIFO's DIN, WR, FULL, almostFULL and OVER.

Parameters:
DW, 16, data width of requester and FIFO data.
BURST_MAX, 4, maximum consecutive transfers granted to one requester while the other is requesting (range 1..15).

Ports:
CLK  in  1  clock; all state updates on rising edge.
RST  in  1  synchronous reset, active-low (0 = reset), sampled on rising CLK.
REQ0  in  1  requester 0 has valid data on DIN0.
DIN0  in  DW  requester 0 data.
ACK0  out  1  ready to requester 0; combinational; transfer occurs on the edge where REQ0 & ACK0.
REQ1  in  1  requester 1 valid.
DIN1  in  DW  requester 1 data.
ACK1  out  1  ready to requester 1; combinational.
F_DIN  out  DW  to FIFO DIN; registered.
F_WR  out  1  to FIFO WR; registered, one-cycle pulse per transfer.
F_FULL  in  1  FIFO FULL.
F_AFULL  in  1  FIFO almostFULL (count == depth-1).
F_OVER  in  1  FIFO OVER.
OWNER  out  1  requester currently owning the grant (valid when BUSY).
BUSY  out  1  FSM not in IDLE.
STALL_CNT  out  16  cycles with a pending granted request blocked by flow control; saturates at 16'hFFFF.
ERR  out  1  sticky; set when F_OVER is seen high.

Behaviour:
- Reset (RST=0 at an edge) applies regardless of state:
  - F_WR=0, F_DIN=0, state=IDLE, OWNER=0, BUSY=0.
  - Burst counter=0, last-served pointer=1 (so requester 0 wins first), STALL_CNT=0, ERR=0.
  - ACK0 and ACK1 are forced 0 while RST=0.
  - An in-flight F_WR is dropped.
- Write allowed: `allow = !F_FULL && !(F_WR && F_AFULL)`.
  - F_WR=1 means a write lands at the current edge and is not yet reflected in the flags.
  - Reads are ignored, which is conservative.
- FSM states and transitions:
  - IDLE:
    - If neither REQ is high, stay in IDLE.
    - If exactly one REQ is high, go to OWNx for that requester.
    - If both are high, go to OWN of the requester that is not the last-served one.
    - The transition costs one cycle: no ACK is asserted in IDLE.
  - OWNx:
    - `ACKx = REQx & allow`; the other ACK is 0.
    - Each transfer: F_WR<=1, F_DIN<=DINx, burst counter +1, last-served<=x.
    - Cycles without a transfer: F_WR<=0.
  - Leaving OWNx, evaluated at each edge:
    - If REQx is low, go to OWNy when REQy is high, else to IDLE.
    - If the burst counter reaches BURST_MAX on this transfer and REQy is high, go to OWNy.
    - On every switch the burst counter resets to 0.
    - If BURST_MAX is reached while REQy is low, the burst counter holds at BURST_MAX and the owner keeps the grant.
- Latency: the data word appears on F_DIN/F_WR exactly one cycle after the handshake edge.
- Throughput: at most one transfer per cycle. A switch between owners costs no idle cycle (OWN0 to OWN1 directly).
- Stalls:
  - STALL_CNT increments on every cycle in OWNx with REQx=1 and allow=0.
  - It saturates and never wraps.
- ERR sets on F_OVER=1 and clears only on reset.
- A requester must hold REQx and DINx stable until ACKx is seen. The arbiter never deasserts ACKx mid-cycle once REQx is stable.

Optional Feature:
FIFO_WR_ARB_STRICT_PRIO_EN
- Defined:
  - Requester 0 has fixed priority. From IDLE with both requesting, grant 0.
  - In OWN1, if REQ0 rises, switch to OWN0 after the current edge regardless of burst.
  - BURST_MAX applies only to OWN0; when reached with REQ1 high, yield to 1 for one transfer.
  - Starvation of 1 is thus bounded at BURST_MAX.
- Undefined: round-robin as described above.

Test Plan:
1. Reset mid-burst: REQ0=1 streaming 3 words, then RST=0 for 1 cycle. Required: F_WR=0, ACK0=0, BUSY=0 on the next cycle; after release, the first grant goes to 0.
2. Single requester fill: REQ0=1, DIN0=0..10, FIFO never read. Required:
   - Exactly 8 F_WR pulses, data 0..7.
   - ACK0 low from the 9th word on.
   - STALL_CNT increments every held cycle.
   - ERR stays 0.
3. Round-robin: REQ0=REQ1=1 continuously, DIN0=16'hA000+n, DIN1=16'hB000+n, FIFO read every cycle. Required F_DIN sequence: A000..A003, B000..B003, A004..A007, with no gaps in F_WR.
4. Almost-full boundary: preload 6 words, then REQ1=1 with 16'hD, 16'hE, 16'hF back-to-back. Required: D and E written, F held (ACK1=0) until a FIFO read clears FULL, then F written; F_OVER is never seen.
5. Early release: in OWN0, REQ0 drops after 2 words while REQ1=1. Required: OWNER=1 on the following cycle, with burst counting restarting at 0.
6. FIFO_WR_ARB_STRICT_PRIO_EN: REQ1 streaming, REQ0 raised at cycle 5. Required: the next F_DIN after the in-flight word comes from DIN0.
